// File: rtl/lane_pipe.sv
// Multi-lane in-order pipeline register chain between issue and writeback.
// Per-stage stall and kill, bubble insertion, optional zeroing of dead data, and a saturating stall counter.

module lane_pipe_lane #(
    parameter int DEPTH       = 3,
    parameter int WIDTH       = 32,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [DEPTH-1:0]             i_adv,
    input  logic [DEPTH-1:0]             i_kill,
    input  logic                         i_valid,
    input  logic                         i_kill_in,
    input  logic [WIDTH-1:0]             i_data,
    output logic [DEPTH-1:0]             o_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]  o_data
);
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            w_ev;
    logic [DEPTH-1:0]            w_nvalid;
    logic [DEPTH-1:0][WIDTH-1:0] w_ndata;
    logic [DEPTH-1:0]            w_src_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
    logic [DEPTH-1:0]            w_src_adv;

    assign w_ev = r_valid & ~i_kill;

    // Source of each stage: the input port for stage 0, the next-younger stage otherwise.
    for (genvar s = 0; s < DEPTH; s++) begin : g_src
        if (s == 0) begin : g_first
            assign w_src_v[s]   = i_valid & ~i_kill_in;
            assign w_src_d[s]   = i_data;
            assign w_src_adv[s] = 1'b1;
        end else begin : g_rest
            assign w_src_v[s]   = w_ev[s-1];
            assign w_src_d[s]   = r_data[s-1];
            assign w_src_adv[s] = i_adv[s-1];
        end
    end

    always_comb begin
        w_nvalid = w_ev;
        w_ndata  = r_data;
        for (int s = 0; s < DEPTH; s++) begin
            if (i_adv[s]) begin
                if (w_src_adv[s]) begin
                    w_nvalid[s] = w_src_v[s];
                    w_ndata[s]  = w_src_d[s];
                end else begin
                    w_nvalid[s] = 1'b0;
                end
            end
            if (ZERO_BUBBLE != 0 && !w_nvalid[s])
                w_ndata[s] = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_nvalid;
            r_data  <= w_ndata;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

module lane_pipe #(
    parameter int LANES       = 2,
    parameter int DEPTH       = 3,
    parameter int WIDTH       = 32,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [LANES-1:0]             in_valid_i,
    input  logic [LANES*WIDTH-1:0]       in_data_i,
    output logic                         in_ready_o,
    input  logic [DEPTH-1:0]             stall_i,
    input  logic [DEPTH*LANES-1:0]       kill_i,
    input  logic                         kill_in_i,
    output logic [DEPTH*LANES-1:0]       stage_valid_o,
    output logic [DEPTH*LANES*WIDTH-1:0] stage_data_o,
    output logic [LANES-1:0]             out_valid_o,
    output logic [LANES*WIDTH-1:0]       out_data_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    input  logic                         stall_cnt_clr_i
);
    logic [DEPTH-1:0]                        w_adv;
    logic [LANES-1:0][DEPTH-1:0]             w_kill;
    logic [LANES-1:0][DEPTH-1:0]             w_lv;
    logic [LANES-1:0][DEPTH-1:0][WIDTH-1:0]  w_ld;
    logic [CNT_W-1:0]                        r_cnt;

    // A stall anywhere at or beyond stage s freezes stage s.
    for (genvar s = 0; s < DEPTH; s++) begin : g_adv
        assign w_adv[s] = ~|stall_i[DEPTH-1:s];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < DEPTH; s++) begin : g_map
            assign w_kill[l][s] = kill_i[s*LANES+l];
            assign stage_valid_o[s*LANES+l] = w_lv[l][s];
            assign stage_data_o[(s*LANES+l)*WIDTH +: WIDTH] = w_ld[l][s];
        end

        lane_pipe_lane #(
            .DEPTH       (DEPTH),
            .WIDTH       (WIDTH),
            .ZERO_BUBBLE (ZERO_BUBBLE)
        ) u_lane (
            .clock_i   (clock_i),
            .reset_n_i (reset_n_i),
            .i_adv     (w_adv),
            .i_kill    (w_kill[l]),
            .i_valid   (in_valid_i[l]),
            .i_kill_in (kill_in_i),
            .i_data    (in_data_i[l*WIDTH +: WIDTH]),
            .o_valid   (w_lv[l]),
            .o_data    (w_ld[l])
        );

        assign out_valid_o[l]              = w_lv[l][DEPTH-1];
        assign out_data_o[l*WIDTH +: WIDTH] = w_ld[l][DEPTH-1];
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_cnt <= '0;
        else if (stall_cnt_clr_i)
            r_cnt <= '0;
        else if (!w_adv[0] && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end

    assign in_ready_o  = w_adv[0];
    assign stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_lane_pipe.sv
// Bench for lane_pipe: directed scenarios plus randomized traffic against an array-based model.
module tb_lane_pipe;
    localparam int L = 2;
    localparam int D = 3;
    localparam int W = 16;
    localparam int C = 4;
    localparam int CMAX = (1 << C) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [L-1:0]     in_valid;
    logic [L*W-1:0]   in_data;
    logic             in_ready;
    logic [D-1:0]     stall;
    logic [D*L-1:0]   kill;
    logic             kill_in;
    logic [D*L-1:0]   stage_valid;
    logic [D*L*W-1:0] stage_data;
    logic [L-1:0]     out_valid;
    logic [L*W-1:0]   out_data;
    logic [C-1:0]     cnt;
    logic             clr;

    int checks = 0;
    int failures = 0;

    logic           mv[D][L];
    logic [W-1:0]   md[D][L];
    int             mcnt;

    always #5 clk = ~clk;

    lane_pipe #(.LANES(L), .DEPTH(D), .WIDTH(W), .ZERO_BUBBLE(1), .CNT_W(C)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .stall_i(stall), .kill_i(kill), .kill_in_i(kill_in),
        .stage_valid_o(stage_valid), .stage_data_o(stage_data), .out_valid_o(out_valid),
        .out_data_o(out_data), .stall_cnt_o(cnt), .stall_cnt_clr_i(clr)
    );

    task automatic idle();
        in_valid = '0; in_data = '0; stall = '0; kill = '0; kill_in = 1'b0; clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < D; s++)
            for (int l = 0; l < L; l++) begin
                mv[s][l] = 1'b0; md[s][l] = '0;
            end
        mcnt = 0;
    endtask

    // Applies the transfer rules to the model using the inputs present before the edge.
    task automatic tick();
        logic         nv[D][L];
        logic [W-1:0] nd[D][L];
        logic         adv[D];
        int           ncnt;
        for (int s = 0; s < D; s++) begin
            adv[s] = 1'b1;
            for (int j = s; j < D; j++) if (stall[j]) adv[s] = 1'b0;
        end
        for (int s = 0; s < D; s++)
            for (int l = 0; l < L; l++) begin
                if (!adv[s]) begin
                    nv[s][l] = mv[s][l] & ~kill[s*L+l];
                    nd[s][l] = md[s][l];
                end else if (s == 0) begin
                    nv[s][l] = in_valid[l] & ~kill_in;
                    nd[s][l] = in_data[l*W +: W];
                end else if (adv[s-1]) begin
                    nv[s][l] = mv[s-1][l] & ~kill[(s-1)*L+l];
                    nd[s][l] = md[s-1][l];
                end else begin
                    nv[s][l] = 1'b0;
                    nd[s][l] = md[s][l];
                end
                if (!nv[s][l]) nd[s][l] = '0;
            end
        if (clr) ncnt = 0;
        else if (!adv[0]) ncnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
        else ncnt = mcnt;
        @(posedge clk);
        #1;
        mv = nv; md = nd; mcnt = ncnt;
    endtask

    // E0 ends in stage 2, E1 in stage 1, E2 in stage 0; the counter is cleared on the way.
    task automatic fill();
        idle();
        clr = 1'b1; in_valid = 2'b11; in_data = {16'h0011, 16'h0010}; tick();
        clr = 1'b0; in_data = {16'h0021, 16'h0020}; tick();
        in_data = {16'h0031, 16'h0030}; tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stage_valid !== '0) begin failures++; $display("FAIL reset_valid got=%h exp=0", stage_valid); end
        checks++; if (stage_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", stage_data); end
        checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        idle();
        in_valid = 2'b11; in_data = {16'h0002, 16'h0001};
        tick();
        idle();
        checks++; if (stage_valid[1:0] !== 2'b11) begin failures++; $display("FAIL lat_s0_valid got=%b exp=11", stage_valid[1:0]); end
        tick();
        checks++; if (stage_valid[3:2] !== 2'b11) begin failures++; $display("FAIL lat_s1_valid got=%b exp=11", stage_valid[3:2]); end
        checks++; if (stage_data[2*W +: 2*W] !== 32'h0002_0001) begin failures++; $display("FAIL lat_s1_data got=%h exp=00020001", stage_data[2*W +: 2*W]); end
        tick();
        checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL lat_out_valid got=%b exp=11", out_valid); end
        checks++; if (out_data !== 32'h0002_0001) begin failures++; $display("FAIL lat_out_data got=%h exp=00020001", out_data); end
        checks++; if (stage_valid[1:0] !== 2'b00) begin failures++; $display("FAIL lat_s0_empty got=%b exp=00", stage_valid[1:0]); end
    endtask

    task automatic test_stall();
        fill();
        stall = 3'b010; in_valid = 2'b11; in_data = {16'h0041, 16'h0040};
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (stage_valid !== 6'b00_11_11) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=001111", k, stage_valid); end
            checks++; if (stage_data !== {32'h0, 32'h0021_0020, 32'h0031_0030}) begin failures++; $display("FAIL stall_data[%0d] got=%h", k, stage_data); end
        end
        checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", cnt); end
        idle();
        tick();
        checks++; if (out_valid !== 2'b11 || out_data !== 32'h0021_0020) begin failures++; $display("FAIL stall_release got=%b/%h exp=11/00210020", out_valid, out_data); end
        checks++; if (stage_data[2*W +: 2*W] !== 32'h0031_0030) begin failures++; $display("FAIL stall_release_s1 got=%h exp=00310030", stage_data[2*W +: 2*W]); end
    endtask

    task automatic test_kill();
        fill();
        kill = 6'b001000;
        tick();
        idle();
        checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL kill_valid got=%b exp=01", out_valid); end
        checks++; if (out_data !== 32'h0000_0020) begin failures++; $display("FAIL kill_data got=%h exp=00000020", out_data); end
    endtask

    task automatic test_stall_kill();
        fill();
        stall = 3'b100; kill = 6'b010000;
        tick();
        idle();
        checks++; if (stage_valid !== 6'b10_11_11) begin failures++; $display("FAIL sk_valid got=%b exp=101111", stage_valid); end
        checks++; if (stage_data !== {32'h0011_0000, 32'h0021_0020, 32'h0031_0030}) begin failures++; $display("FAIL sk_data got=%h", stage_data); end
    endtask

    task automatic test_saturate();
        idle();
        clr = 1'b1; tick();
        clr = 1'b0; stall = 3'b001;
        repeat ((1 << C) + 5) tick();
        checks++; if (cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", cnt); end
        clr = 1'b1;
        tick();
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", cnt); end
        clr = 1'b0;
        tick();
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL sat_restart got=%0d exp=1", cnt); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid = L'($urandom);
            in_data  = {W'($urandom), W'($urandom)};
            stall    = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
            kill     = ($urandom_range(0, 3) == 0) ? (D*L)'($urandom) : '0;
            kill_in  = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 31) == 0);
            #1;
            checks++; if (in_ready !== (stall == '0)) begin failures++; $display("FAIL rnd_ready[%0d] got=%b", n, in_ready); end
            tick();
            for (int s = 0; s < D; s++)
                for (int l = 0; l < L; l++) begin
                    checks++;
                    if (stage_valid[s*L+l] !== mv[s][l] || stage_data[(s*L+l)*W +: W] !== md[s][l]) begin
                        failures++;
                        $display("FAIL rnd_stage[%0d] s%0d l%0d got=%b/%h exp=%b/%h", n, s, l,
                                 stage_valid[s*L+l], stage_data[(s*L+l)*W +: W], mv[s][l], md[s][l]);
                    end
                end
            checks++; if (int'(cnt) !== mcnt) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, cnt, mcnt); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        fill();
        stall = 3'b001; tick();
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (stage_valid !== '0) begin failures++; $display("FAIL areset_valid got=%b exp=0", stage_valid); end
        checks++; if (stage_data !== '0) begin failures++; $display("FAIL areset_data got=%h exp=0", stage_data); end
        checks++; if (cnt !== '0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", cnt); end
        #2;
        rst_n = 1'b1;
        in_valid = 2'b01; in_data = {16'h0000, 16'h0055};
        tick();
        idle();
        checks++; if (stage_valid !== 6'b00_00_01) begin failures++; $display("FAIL areset_cap_valid got=%b exp=000001", stage_valid); end
        checks++; if (stage_data[W-1:0] !== 16'h0055) begin failures++; $display("FAIL areset_cap_data got=%h exp=0055", stage_data[W-1:0]); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_kill();
        test_stall_kill();
        test_saturate();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lane_pipe.md
Name: lane_pipe

Overview:
- Parametrised multi-lane in-order pipeline register chain with valid tracking, per-stage stall, bubble insertion, selective kill and a stall-cycle counter.
- Generalises the fixed dual-slot issue→exec→lsu→wb buffering to LANES lanes and DEPTH stages.
- Sits between issue and writeback. Downstream stage logic taps each stage's valid/data. The core's hazard unit drives the stall_i and kill_i requests.

Parameters:
LANES, 2, number of parallel lanes (≥1)
DEPTH, 3, number of register stages (≥1)
WIDTH, 32, payload bits per lane per stage
ZERO_BUBBLE, 1, 1 = data forced to 0 wherever valid is 0; 0 = data left stale
CNT_W, 16, stall counter width

Ports:
clock_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
in_valid_i  in  LANES  per-lane valid of incoming entry
in_data_i  in  LANES*WIDTH  incoming payload, lane l at [l*WIDTH +: WIDTH]
in_ready_o  out  1  stage 0 accepts this cycle (=adv[0])
stall_i  in  DEPTH  bit s: stage s must hold
kill_i  in  DEPTH*LANES  bit s*LANES+l: invalidate stage s lane l contents
kill_in_i  in  1  discard the incoming entry (all lanes)
stage_valid_o  out  DEPTH*LANES  registered valid of every stage/lane
stage_data_o  out  DEPTH*LANES*WIDTH  registered payload of every stage/lane
out_valid_o  out  LANES  stage DEPTH-1 valid
out_data_o  out  LANES*WIDTH  stage DEPTH-1 payload
stall_cnt_o  out  CNT_W  saturating count of cycles with in_ready_o=0
stall_cnt_clr_i  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Reset (async, reset_n_i low): all valid=0, all data=0, stall_cnt_o=0. Outputs are valid the cycle after release.
- adv[s] = NOR(stall_i[DEPTH-1:s]). A stall at stage s freezes s and all younger stages (lower index). Combinational, no registered delay.
- Effective contents: ev[s][l] = valid[s][l] & ~kill_i[s][l]. Input effective valid: ein[l] = in_valid_i[l] & ~kill_in_i.
- Next state per stage s, lane l:
  - adv[s]=1, s=0: valid←ein[l], data←in_data_i lane l.
  - adv[s]=1, s>0, adv[s-1]=1: valid←ev[s-1][l], data←stage s-1 data.
  - adv[s]=1, s>0, adv[s-1]=0: bubble; valid←0.
  - adv[s]=0: valid←ev[s][l], data held. Kill applies even while stalled.
- Data moves alongside valid. With ZERO_BUBBLE=1, any stage/lane whose next valid is 0 loads data=0.
- Lanes are independent in valid. All lanes of a stage share adv (lock-step).
- Latency: an entry accepted at edge N appears at stage k after edge N+k if there are no stalls. out_* equal stage DEPTH-1, so it is visible DEPTH-1 cycles after capture.
- No implicit consumption. The last stage is overwritten on advance unless stall_i[DEPTH-1]=1.
- kill_i on a stage that is simultaneously advancing prevents that entry propagating. Its old slot is refilled normally.
- kill_in_i with adv[0]=0 has no effect, since nothing is captured.
- Simultaneous stall_i and kill_i on the same stage: the stage holds, and the killed lanes go invalid.
- Counter:
  - stall_cnt_clr_i has priority and sets the counter to 0.
  - Otherwise it increments when adv[0]=0, saturating at 2^CNT_W-1 with no wrap.
- DEPTH=1: only the s=0 rules apply. out_* = stage 0.

Test Plan:
1. LANES=2, DEPTH=3, ZERO_BUBBLE=1. Drive valid=2'b11, data {B,A}=0x2,0x1 at cycle 0 with no stalls → out_valid=11, out_data={0x2,0x1} after edge 3. Stage 1 shows them after edge 2.
2. Fill stages with entries E0(s2), E1(s1), E2(s0), then stall_i=3'b010 for 2 cycles → s0/s1 hold E2/E1, in_ready_o=0. Stage 2 holds bubble valid=0, data=0 on both edges. stall_cnt_o increments by 2. After release, E1 reaches stage 2 on the next edge.
3. kill_i stage1 lane1 while advancing → lane1 at stage2 valid=0 next cycle. Lane0 propagates with value intact.
4. stall_i[2]=1 plus kill_i stage2 lane0 → stage2 lane0 valid=0, lane1 unchanged. All stages hold.
5. Hold stall_i[0]=1 for 2^CNT_W+5 cycles (CNT_W=4) → stall_cnt_o sticks at 15. Pulse stall_cnt_clr_i together with the stall → 0 next cycle.
6. Assert reset_n_i low mid-stream between edges → all stage_valid_o=0, data=0, and counter=0 immediately (asynchronously). The first capture after release appears at stage 0 on the next edge.
